// File: rtl/fifo_sync_reader_pkg.sv
// Shared definitions for the delayed-word reader: default sizing and FSM state encoding.
package fifo_sync_reader_pkg;

    localparam int unsigned FIFO_WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF      = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } rd_state_t;

endpackage

// File: rtl/fifo_sync_reader_rd_buf_fifo.sv
// DEPTH x FIFO_WIDTH buffer with first-word-fall-through read and a separate level counter.
module rd_buf_fifo
    import fifo_sync_reader_pkg::*;
#(
    parameter  int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter  int unsigned DEPTH      = DEPTH_DEF,
    localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [FIFO_WIDTH-1:0] wdata_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [FIFO_WIDTH-1:0] rdata_o,
    output logic [ADDR_W:0]       level_o
);

    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

    logic [FIFO_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]       level_q, level_d;
    logic                  do_push, do_pop;

    // Full/empty come from the registered level, so a pop cannot free a slot for a same-cycle push.
    assign full_o  = (level_q == LEVEL_FULL);
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
            2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fifo_sync_reader.sv
// Consumer end of the delayed-word interface: captures data/data_rd words, acks with
// a one-cycle data_use pulse, and buffers them for a valid/ready sink.
module fifo_sync_reader
    import fifo_sync_reader_pkg::*;
#(
    parameter  int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter  int unsigned DEPTH      = DEPTH_DEF,
    localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_i,
    input  logic                  data_rd,
    output logic                  data_use,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [ADDR_W:0]       level_o,
    output logic [15:0]           words_o,
    output logic                  stall_o
);

    rd_state_t   state_q;
    logic        data_use_q;
    logic [15:0] words_q;
    logic        full_w, empty_w, capture_w;

    // The ACK cycle ignores data_rd: the producer still shows the word just taken.
    assign capture_w = (state_q == ST_IDLE) && data_rd && !full_w;
    assign stall_o   = !rst && (state_q == ST_IDLE) && data_rd && full_w;

    assign data_use = data_use_q;
    assign words_o  = words_q;
    assign m_valid  = !empty_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_use_q <= 1'b0;
            words_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (capture_w) begin
                        words_q    <= words_q + 16'd1;
                        data_use_q <= 1'b1;
                        state_q    <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    data_use_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    rd_buf_fifo #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .DEPTH      (DEPTH)
    ) u_buf (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (capture_w),
        .wdata_i (data_i),
        .pop_i   (m_ready),
        .full_o  (full_w),
        .empty_o (empty_w),
        .rdata_o (m_data),
        .level_o (level_o)
    );

endmodule

// File: tb/tb_fifo_sync_reader.sv
// Directed bench for fifo_sync_reader with a capture-order scoreboard on the sink side.
module tb_fifo_sync_reader;
    import fifo_sync_reader_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned AW = $clog2(D);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  data_i = '0;
    logic          data_rd = 1'b0;
    logic          data_use;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready = 1'b0;
    logic [AW:0]   level_o;
    logic [15:0]   words_o;
    logic          stall_o;

    int            vectors = 0;
    int            miscompares = 0;
    logic [W-1:0]  sb[$];
    int unsigned   words_exp = 0;
    int unsigned   sunk = 0;
    int unsigned   sunk_mark;

    always #5 clk = ~clk;

    fifo_sync_reader #(
        .FIFO_WIDTH (W),
        .DEPTH      (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_i   (data_i),
        .data_rd  (data_rd),
        .data_use (data_use),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .level_o  (level_o),
        .words_o  (words_o),
        .stall_o  (stall_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check sink-side state against the scoreboard, then advance past the edge.
    task automatic tick();
        logic [W-1:0] e;
        #1;
        chk("m_valid", 32'(m_valid), 32'(sb.size() != 0));
        if (sb.size() < D) chk("no_stall", 32'(stall_o), 32'd0);
        if (m_ready && sb.size() != 0) begin
            e = sb.pop_front();
            chk("sink_data", 32'(m_data), 32'(e));
            sunk++;
        end
        @(posedge clk);
        #1;
    endtask

    // Present a word and take the capture edge; leaves data_rd high for the ACK cycle.
    task automatic send(input logic [W-1:0] d);
        data_i  = d;
        data_rd = 1'b1;
        tick();
        sb.push_back(d);
        words_exp++;
        chk("ack", 32'(data_use), 32'd1);
        chk("words", 32'(words_o), 32'(words_exp));
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 12 && sb.size() != 0; i++) tick();
        m_ready = 1'b0;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $error("FAIL drain_timeout: observed %0d left expected 0", sb.size());
        end
        chk("drain_level", 32'(level_o), 32'd0);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_use", 32'(data_use), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_words", 32'(words_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        tick();

        // 1: single word, one-cycle ack
        send(8'hA5);
        chk("t1_data", 32'(m_data), 32'hA5);
        tick();
        data_rd = 1'b0;
        chk("t1_ack_low", 32'(data_use), 32'd0);
        chk("t1_words", 32'(words_o), 32'd1);
        tick();
        chk("t1_ack_low2", 32'(data_use), 32'd0);
        drain();

        // 2: fill to DEPTH, fifth word stalls until one pop
        for (int k = 0; k < 4; k++) begin
            send(8'(8'h10 + k));
            tick();
            data_rd = 1'b0;
            tick();
            tick();
        end
        chk("t2_level4", 32'(level_o), 32'd4);
        data_i  = 8'h14;
        data_rd = 1'b1;
        tick();
        chk("t2_stall", 32'(stall_o), 32'd1);
        chk("t2_noack", 32'(data_use), 32'd0);
        chk("t2_level_hold", 32'(level_o), 32'd4);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("t2_noack_pop", 32'(data_use), 32'd0);
        chk("t2_level3", 32'(level_o), 32'd3);
        tick();
        sb.push_back(8'h14);
        words_exp++;
        chk("t2_ack5", 32'(data_use), 32'd1);
        chk("t2_level_back", 32'(level_o), 32'd4);
        chk("t2_words", 32'(words_o), 32'(words_exp));
        data_rd = 1'b0;
        tick();
        drain();

        // 3: back-to-back producer reloads with data_rd held high
        sunk_mark = sunk;
        m_ready = 1'b1;
        send(8'h01);
        tick();
        chk("t3_gap1", 32'(data_use), 32'd0);
        send(8'h02);
        tick();
        send(8'h03);
        tick();
        data_rd = 1'b0;
        tick();
        m_ready = 1'b0;
        chk("t3_sunk", 32'(sunk - sunk_mark), 32'd3);
        chk("t3_level", 32'(level_o), 32'd0);

        // 4: simultaneous capture and pop at level 2
        send(8'h41);
        tick();
        data_rd = 1'b0;
        tick();
        send(8'h42);
        tick();
        data_rd = 1'b0;
        tick();
        chk("t4_level2", 32'(level_o), 32'd2);
        chk("t4_head", 32'(m_data), 32'h41);
        m_ready = 1'b1;
        send(8'h43);
        m_ready = 1'b0;
        chk("t4_level_same", 32'(level_o), 32'd2);
        chk("t4_head_adv", 32'(m_data), 32'h42);
        data_rd = 1'b0;
        tick();
        drain();

        // 5: reset during ACK with three words held
        send(8'h51);
        tick();
        data_rd = 1'b0;
        tick();
        send(8'h52);
        tick();
        data_rd = 1'b0;
        tick();
        send(8'h53);
        chk("t5_level3", 32'(level_o), 32'd3);
        rst = 1'b1;
        data_rd = 1'b0;
        tick();
        sb.delete();
        words_exp = 0;
        chk("t5_use", 32'(data_use), 32'd0);
        chk("t5_valid", 32'(m_valid), 32'd0);
        chk("t5_level", 32'(level_o), 32'd0);
        chk("t5_words", 32'(words_o), 32'd0);
        rst = 1'b0;
        tick();
        send(8'h77);
        chk("t5_data", 32'(m_data), 32'h77);
        tick();
        data_rd = 1'b0;
        tick();
        drain();

        // 6: ten words with random sink readiness across pointer wrap
        rst = 1'b1;
        tick();
        sb.delete();
        words_exp = 0;
        rst = 1'b0;
        tick();
        sunk_mark = sunk;
        for (int k = 0; k < 10; k++) begin
            for (int g = 0; g < 40 && sb.size() == D; g++) begin
                m_ready = 1'($urandom_range(0, 1));
                tick();
            end
            if (sb.size() == D) begin
                vectors++;
                miscompares++;
                $error("FAIL t6_wait: observed level %0d expected below %0d", sb.size(), D);
            end
            m_ready = 1'($urandom_range(0, 1));
            send(8'(8'h60 + k));
            data_rd = 1'b0;
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain();
        chk("t6_words", 32'(words_o), 32'd10);
        chk("t6_sunk", 32'(sunk - sunk_mark), 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
